decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; OUT_W = 2**SEL_W is a derived localparam, not overridable.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-006 SHALL have port in_sel  input  SEL_W  select index.
REQ-007 SHALL have port in_mode  input  2  00 ONEHOT, 01 THERMO, 10 SCAN, 11 reserved.
REQ-008 SHALL have port out_valid  output  1  out carries a valid code.
REQ-009 SHALL have port out_ready  input  1  consumer takes the beat when out_valid && out_ready.
REQ-010 SHALL have port out  output  OUT_W  registered decoded code.
REQ-011 SHALL have port busy  output  1  high while in SCAN state.

Function
REQ-012 SHALL implement FSM states IDLE, HOLD, SCAN.
REQ-013 SHALL drive in_ready = 1 in IDLE, = out_ready in HOLD, = 0 in SCAN (combinational from state and out_ready).
REQ-014 On accept with ONEHOT: out <= only bit in_sel set; next state HOLD; latency 1 cycle, accept edge to out_valid.
REQ-015 On accept with THERMO: out <= bits 0..in_sel set, others 0 (in_sel=7, SEL_W=3 -> 8'hFF); next state HOLD.
REQ-016 On accept with reserved mode 11: out <= all zeros; next state HOLD (one beat emitted).
REQ-017 On accept with SCAN: latch last <= in_sel, counter <= 0, out <= bit 0 set; next state SCAN.
REQ-018 out_valid SHALL be 1 in HOLD and SCAN, 0 in IDLE.
REQ-019 out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 HOLD, out_ready=1, in_valid=1: accept new request same edge, decode per REQ-014..017, no bubble.
REQ-021 HOLD, out_ready=1, in_valid=0: go IDLE; out keeps last value, out_valid=0.
REQ-022 SCAN, out_ready=1, counter != last: counter+1, out <= one-hot of counter+1.
REQ-023 SCAN, out_ready=1, counter == last: go IDLE; no wrap past last; exactly last+1 beats per scan.
REQ-024 SCAN with last=0 SHALL emit exactly one beat (8'h01).
REQ-025 Inputs in_sel and in_mode SHALL be ignored when not accepted; changing in_sel mid-scan has no effect.
REQ-026 busy = 1 iff state is SCAN.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, out = 0, out_valid = 0, counter = 0, last = 0, busy = 0, in_ready = 1, regardless of clk.
REQ-028 Reset mid-scan or mid-HOLD SHALL drop the pending beat; no beat emitted after release until a new accept.
REQ-029 First accept SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-030 Package decoder_pkg SHALL hold mode enum (MODE_ONEHOT, MODE_THERMO, MODE_SCAN, MODE_RSVD) and state enum (IDLE, HOLD, SCAN).
REQ-031 Combinational sub-module decoder_core (sel, mode -> OUT_W code) SHALL be instantiated for all code generation, including scan steps.
REQ-032 RTL SHALL be synthesizable for any SEL_W 1..6.

Verification
REQ-033 SEL_W=3, ONEHOT sel 0..7 back-to-back, out_ready=1 -> out 01,02,04,...,80 on consecutive cycles, one beat per cycle.
REQ-034 THERMO sel=3, out_ready=0 for 4 cycles then 1 -> out=8'h0F held stable 5 cycles, single beat.
REQ-035 SCAN sel=5, out_ready=1 -> 6 beats 01,02,04,08,10,20; busy high 6 cycles; in_ready=0 throughout.
REQ-036 SCAN sel=7 with out_ready toggling 1/0 -> 8 beats in order, none duplicated or skipped.
REQ-037 rst_n low during SCAN beat 3 -> out=0, out_valid=0, busy=0 before next clk edge; idle after release.
REQ-038 Mode 11 sel=4 -> one beat out=8'h00; SEL_W=4 ONEHOT sel=15 -> out=16'h8000.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the decoder/scan block: request modes and controller states.
package decoder_pkg;

  // Request mode as carried on in_mode.
  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Controller states. The fourth encoding is unused and falls back to IDLE behaviour.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    SCAN = 2'b10
  } state_t;

endpackage

// File: rtl/decoder_core.sv
// Combinational code generator: turns a select index and a mode into an OUT_W-bit code.
// ONEHOT and SCAN both produce a one-hot code; THERMO fills bits 0..sel; reserved gives zero.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]        sel,
  input  mode_t                   mode,
  output logic [(1<<SEL_W)-1:0]   code
);

  localparam int OUT_W = 1 << SEL_W;

  logic is_onehot;
  logic is_thermo;

  assign is_onehot = (mode == MODE_ONEHOT) || (mode == MODE_SCAN);
  assign is_thermo = (mode == MODE_THERMO);

  // One comparator per output bit against that bit's own index.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_bit
      localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
      assign code[gi] = is_thermo ? (IDX <= sel) :
                        is_onehot ? (sel == IDX) : 1'b0;
    end
  endgenerate

endmodule

// File: rtl/decoder_scan.sv
// Decoder with a valid/ready front and back end. Single-shot modes emit one beat
// (HOLD); SCAN mode walks a one-hot code from bit 0 up to the latched select index.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<SEL_W)-1:0]  out,
  output logic                   busy
);

  localparam int               OUT_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  last_q, last_d;

  mode_t             in_mode_e;
  logic              accept;
  logic [SEL_W-1:0]  core_sel;
  mode_t             core_mode;
  logic [OUT_W-1:0]  core_code;

  assign in_mode_e = mode_t'(in_mode);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD) || (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign out       = out_q;

  // Front-end handshake: free in IDLE, chained to the consumer in HOLD, closed while scanning.
  always_comb begin
    case (state_q)
      HOLD:    in_ready = out_ready;
      SCAN:    in_ready = 1'b0;
      default: in_ready = 1'b1;
    endcase
  end

  // Steer the shared decoder: next scan step while scanning, otherwise the incoming request
  // (a new scan always starts at bit 0).
  always_comb begin
    core_sel  = in_sel;
    core_mode = in_mode_e;
    if (state_q == SCAN) begin
      core_sel  = cnt_q + ONE;
      core_mode = MODE_ONEHOT;
    end else if (in_mode_e == MODE_SCAN) begin
      core_sel  = '0;
    end
  end

  decoder_core #(
    .SEL_W (SEL_W)
  ) u_core (
    .sel  (core_sel),
    .mode (core_mode),
    .code (core_code)
  );

  // Next-state logic: accept a request, retire a HOLD beat, or advance/finish a scan.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (accept) begin
      out_d = core_code;
      if (in_mode_e == MODE_SCAN) begin
        state_d = SCAN;
        cnt_d   = '0;
        last_d  = in_sel;
      end else begin
        state_d = HOLD;
      end
    end else begin
      case (state_q)
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        SCAN: begin
          if (out_ready) begin
            if (cnt_q == last_q) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + ONE;
              out_d = core_code;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset drops any pending beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: expected beats are queued when requests are driven
// and popped by a monitor whenever the DUT hands over a beat.
module tb_decoder_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out;
  logic        busy;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  in_sel4 = '0;
  logic [1:0]  in_mode4 = '0;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [15:0] out4;
  logic        busy4;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          beats   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  decoder_scan #(.SEL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_sel(in_sel4), .in_mode(in_mode4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out(out4), .busy(busy4)
  );

  // Beat monitor: a beat transfers at the next rising edge if valid&&ready is seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      beats++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got out=%h, required no beat", out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out !== mon_exp) begin
          n_fail++;
          $display("FAIL beat_value: got out=%h, required %h", out, mon_exp);
        end else begin
          $display("[TB] beat out=%h ok", out);
        end
      end
    end
  end

  task automatic drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h v=%b busy=%b rdy=%b, required 00 0 0 1",
               out, out_valid, busy, in_ready);
    end
    // First accept on the first edge after release.
    @(posedge clk); #2;
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 3'd2; in_mode = 2'b00; out_ready = 1'b1;
    exp_q.push_back(8'h04);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out !== 8'h04) begin
      n_fail++;
      $display("FAIL first_accept: got v=%b out=%h, required 1 04", out_valid, out);
    end
    drain(5);
  endtask

  task automatic test_onehot_b2b();
    int b0;
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_mode = 2'b00;
      exp_q.push_back(8'(1) << i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (beats - b0 != 8 || cyc != 1) begin
      n_fail++;
      $display("FAIL onehot_b2b_rate: got %0d beats, %0d extra cycles, required 8 beats, 1 cycle",
               beats - b0, cyc);
    end
    drain(5);
  endtask

  task automatic test_thermo_stall();
    int b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 3'd3; in_mode = 2'b01;
    exp_q.push_back(8'h0F);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sel = 3'd6; in_mode = 2'b00;
    b0 = beats;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out !== 8'h0F) begin
        n_fail++;
        $display("FAIL thermo_hold_%0d: got v=%b out=%h, required 1 0f", k, out_valid, out);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (beats - b0 != 1 || out_valid !== 1'b0 || out !== 8'h0F) begin
      n_fail++;
      $display("FAIL thermo_release: got beats=%0d v=%b out=%h, required 1 0 0f",
               beats - b0, out_valid, out);
    end
    drain(3);
  endtask

  task automatic test_scan5();
    int busy_cnt = 0;
    int rdy_bad = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 3'd5; in_mode = 2'b10;
    for (int j = 0; j < 6; j++) exp_q.push_back(8'(1) << j);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sel = 3'd1; in_mode = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (in_ready !== ~busy) rdy_bad++;
    end
    n_tests++;
    if (busy_cnt != 6) begin
      n_fail++;
      $display("FAIL scan5_busy: got %0d busy cycles, required 6", busy_cnt);
    end
    n_tests++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL scan5_in_ready: got %0d cycles with in_ready==busy, required 0", rdy_bad);
    end
    drain(2);
  endtask

  task automatic test_scan_toggle();
    int b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 3'd7; in_mode = 2'b10;
    for (int j = 0; j < 8; j++) exp_q.push_back(8'(1) << j);
    @(posedge clk); #1;
    in_valid = 1'b0;
    b0 = beats;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain(2);
    n_tests++;
    if (beats - b0 != 8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_toggle_count: got %0d beats busy=%b, required 8 0", beats - b0, busy);
    end
  endtask

  task automatic test_reset_midscan();
    int b0;
    int bad = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 3'd7; in_mode = 2'b10;
    for (int j = 0; j < 8; j++) exp_q.push_back(8'(1) << j);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (out !== 8'h04 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_beat3: got out=%h busy=%b, required 04 1", out, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_reset: got out=%h v=%b busy=%b rdy=%b, required 00 0 0 1",
               out, out_valid, busy, in_ready);
    end
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    b0 = beats;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || beats != b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d valid cycles %0d beats, required 0 0",
               bad, beats - b0);
    end
  endtask

  task automatic test_rsvd();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 3'd4; in_mode = 2'b11;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || out !== 8'h00) begin
      n_fail++;
      $display("FAIL rsvd_mode: got v=%b busy=%b out=%h, required 1 0 00", out_valid, busy, out);
    end
    drain(3);
  endtask

  task automatic test_wide();
    @(posedge clk); #1;
    in_valid4 = 1'b1; in_sel4 = 4'd15; in_mode4 = 2'b00;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid4 !== 1'b1 || out4 !== 16'h8000) begin
      n_fail++;
      $display("FAIL wide_onehot15: got v=%b out=%h, required 1 8000", out_valid4, out4);
    end else $display("[TB] wide onehot sel=15 out=%h ok", out4);
    in_sel4 = 4'd9; in_mode4 = 2'b01;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n_tests++;
    if (out_valid4 !== 1'b1 || out4 !== 16'h03FF) begin
      n_fail++;
      $display("FAIL wide_thermo9: got v=%b out=%h, required 1 03ff", out_valid4, out4);
    end else $display("[TB] wide thermo sel=9 out=%h ok", out4);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_onehot_b2b();
    test_thermo_stall();
    test_scan5();
    test_scan_toggle();
    test_reset_midscan();
    test_rsvd();
    test_wide();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d outstanding beats, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
